inst_fetch_ctrl: RTL and testbench

- Program-counter sequencer that drives the instruction memory's InstAddress.
- Steps the PC through the loaded program and applies taken branches, either PC-relative or through a 64-entry branch-target LUT.
- Handles stall from the datapath and halt detection.
- Exposes a Start/Done handshake to the testbench/top level.

---
 rtl/inst_fetch_ctrl.sv | 148 ++++++++++++++
 tb/tb_inst_fetch_ctrl.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch_ctrl.sv
// inst_fetch_ctrl: program-counter sequencer for the instruction memory.
// Steps the PC through the program, and applies taken branches either
// PC-relative or through a branch-target LUT. It handles datapath stalls
// and halt, and exposes a Start/Done handshake.
// Optional retired-instruction counter: define INST_FETCH_CYCLE_CNT_EN.
module inst_fetch_ctrl #(
  parameter int          A          = 10,
  parameter int          LUT_DEPTH  = 64,
  parameter logic [A-1:0] START_ADDR = '0
) (
  input  logic                         Clk,
  input  logic                         Reset,
  input  logic                         Start,
  input  logic                         Stall,
  input  logic                         Halt,
  input  logic                         BranchEn,
  input  logic                         BranchMode,
  input  logic [5:0]                   BranchField,
  input  logic                         LutWrEn,
  input  logic [$clog2(LUT_DEPTH)-1:0] LutWrIdx,
  input  logic [A-1:0]                 LutWrData,
  output logic [A-1:0]                 InstAddress,
  output logic                         Running,
  output logic                         Done,
  output logic [15:0]                  InstCount
);

  localparam int IW = $clog2(LUT_DEPTH);
  localparam logic [A-1:0] PC_ONE = {{(A-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t       r_state;
  state_t       w_state_next;
  logic [A-1:0] r_pc;
  logic [A-1:0] w_pc_next;
  logic         r_running;
  logic         r_done;

  // Branch-target LUT: plain registers, because every entry must clear on reset.
  logic [A-1:0] r_lut [LUT_DEPTH];
  logic [A-1:0] w_lut_rd;
  logic [IW-1:0] w_lut_idx;
  logic [A-1:0] w_rel_target;

  genvar gi;
  generate
    for (gi = 0; gi < LUT_DEPTH; gi++) begin : g_lut
      // One LUT entry: cleared by reset, loaded when its index is written.
      always_ff @(posedge Clk) begin
        if (Reset) begin
          r_lut[gi] <= '0;
        end else if (LutWrEn && (LutWrIdx == IW'(gi))) begin
          r_lut[gi] <= LutWrData;
        end
      end
    end
  endgenerate

  // LUT read is combinational on the current contents, so a same-cycle write
  // to the same index is not seen by the branch (read before write).
  // Indices beyond the table depth return 0.
  always_comb begin
    w_lut_idx = IW'(BranchField);
    w_lut_rd  = '0;
    if (int'(BranchField) < LUT_DEPTH) begin
      w_lut_rd = r_lut[w_lut_idx];
    end
  end

  // Relative target: sign-extended 6-bit offset, wraps modulo 2^A.
  assign w_rel_target = r_pc + {{(A-6){BranchField[5]}}, BranchField};

  // Next-state and next-PC selection; stall outranks halt, halt outranks branch.
  always_comb begin
    w_state_next = r_state;
    w_pc_next    = r_pc;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (Start) begin
          w_state_next = S_RUN;
          w_pc_next    = START_ADDR;
        end
      end
      S_RUN: begin
        if (!Stall) begin
          if (Halt) begin
            w_state_next = S_DONE;
          end else if (BranchEn) begin
            w_pc_next = BranchMode ? w_lut_rd : w_rel_target;
          end else begin
            w_pc_next = r_pc + PC_ONE;
          end
        end
      end
      default: begin
        w_state_next = S_IDLE;
        w_pc_next    = START_ADDR;
      end
    endcase
  end

  // State, PC and status flags; flags are registered from the next state.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state   <= S_IDLE;
      r_pc      <= START_ADDR;
      r_running <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_pc      <= w_pc_next;
      r_running <= (w_state_next == S_RUN);
      r_done    <= (w_state_next == S_DONE);
    end
  end

  assign InstAddress = r_pc;
  assign Running     = r_running;
  assign Done        = r_done;

`ifdef INST_FETCH_CYCLE_CNT_EN
  logic [15:0] r_inst_count;
  logic        w_start_acc;

  assign w_start_acc = Start && (r_state != S_RUN);

  // Retired count: every unstalled RUN cycle (halt cycle included), saturating.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_inst_count <= 16'd0;
    end else if (w_start_acc) begin
      r_inst_count <= 16'd0;
    end else if ((r_state == S_RUN) && !Stall && (r_inst_count != 16'hFFFF)) begin
      r_inst_count <= r_inst_count + 16'd1;
    end
  end

  assign InstCount = r_inst_count;
`else
  assign InstCount = 16'd0;
`endif

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// Self-checking bench for inst_fetch_ctrl: a behavioural model predicts the
// post-edge outputs when inputs are driven, pushes them to a scoreboard queue,
// and they are popped and compared after the edge. Directed checks against
// hand-derived constants cover the listed scenarios.
module tb_inst_fetch_ctrl;

  logic        Clk = 1'b0;
  always #5 Clk = ~Clk;

  logic        Reset, Start, Stall, Halt, BranchEn, BranchMode, LutWrEn;
  logic [5:0]  BranchField, LutWrIdx;
  logic [9:0]  LutWrData;
  logic [9:0]  InstAddress;
  logic        Running, Done;
  logic [15:0] InstCount;

  inst_fetch_ctrl dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .Start      (Start),
    .Stall      (Stall),
    .Halt       (Halt),
    .BranchEn   (BranchEn),
    .BranchMode (BranchMode),
    .BranchField(BranchField),
    .LutWrEn    (LutWrEn),
    .LutWrIdx   (LutWrIdx),
    .LutWrData  (LutWrData),
    .InstAddress(InstAddress),
    .Running    (Running),
    .Done       (Done),
    .InstCount  (InstCount)
  );

  typedef struct {
    logic [9:0]  pc;
    logic        running;
    logic        done;
    logic [15:0] cnt;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_DONE = 2;

  int          m_state;
  logic [9:0]  m_pc;
  logic [15:0] m_cnt;
  logic [9:0]  m_lut [64];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Reference behaviour for one rising edge, using the currently driven inputs.
  task automatic model_edge();
    logic [9:0] lut_old;
    if (Reset) begin
      m_state = M_IDLE;
      m_pc    = 10'd0;
      m_cnt   = 16'd0;
      for (int i = 0; i < 64; i++) m_lut[i] = 10'd0;
    end else begin
      lut_old = m_lut[BranchField];
      if (m_state == M_RUN) begin
        if (!Stall) begin
`ifdef INST_FETCH_CYCLE_CNT_EN
          if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
`endif
          if (Halt)                     m_state = M_DONE;
          else if (BranchEn && !BranchMode) m_pc = m_pc + {{4{BranchField[5]}}, BranchField};
          else if (BranchEn)            m_pc = lut_old;
          else                          m_pc = m_pc + 10'd1;
        end
      end else if (Start) begin
        m_state = M_RUN;
        m_pc    = 10'd0;
        m_cnt   = 16'd0;
      end
      if (LutWrEn) m_lut[LutWrIdx] = LutWrData;
    end
  endtask

  // One clock: drive inputs, predict, push; after the edge pop and compare.
  task automatic cyc(input logic rs, st, sl, hl, be, bm, input logic [5:0] bf,
                     input logic we, input logic [5:0] wi, input logic [9:0] wd);
    exp_t e;
    exp_t g;
    Reset = rs; Start = st; Stall = sl; Halt = hl;
    BranchEn = be; BranchMode = bm; BranchField = bf;
    LutWrEn = we; LutWrIdx = wi; LutWrData = wd;
    model_edge();
    e.pc = m_pc; e.running = (m_state == M_RUN); e.done = (m_state == M_DONE); e.cnt = m_cnt;
    sb_q.push_back(e);
    @(posedge Clk);
    #1;
    if (sb_q.size() == 0) begin
      n_errors++;
      $display("FAIL sb_underflow: queue empty after edge");
    end else begin
      g = sb_q.pop_front();
      check_val("sb_pc", 32'(InstAddress), 32'(g.pc));
      check_val("sb_running", 32'(Running), 32'(g.running));
      check_val("sb_done", 32'(Done), 32'(g.done));
      check_val("sb_count", 32'(InstCount), 32'(g.cnt));
    end
  endtask

  task automatic nop();
    cyc(0, 0, 0, 0, 0, 0, 6'd0, 0, 6'd0, 10'd0);
  endtask

  task automatic lut_wr(input logic [5:0] idx, input logic [9:0] data);
    cyc(0, 0, 0, 0, 0, 0, 6'd0, 1, idx, data);
  endtask

  task automatic br_rel(input logic [5:0] off);
    cyc(0, 0, 0, 0, 1, 0, off, 0, 6'd0, 10'd0);
  endtask

  task automatic br_lut(input logic [5:0] idx);
    cyc(0, 0, 0, 0, 1, 1, idx, 0, 6'd0, 10'd0);
  endtask

  task automatic run_to(input logic [9:0] target);
    for (int i = 0; i < 1100 && m_pc != target; i++) nop();
    check_val("run_to", 32'(InstAddress), 32'(target));
  endtask

  initial begin
    m_state = M_IDLE; m_pc = 10'd0; m_cnt = 16'd0;
    for (int i = 0; i < 64; i++) m_lut[i] = 10'd0;

    // Reset state
    cyc(1, 0, 0, 0, 0, 0, 6'd0, 0, 6'd0, 10'd0);
    cyc(1, 0, 0, 0, 0, 0, 6'd0, 0, 6'd0, 10'd0);
    check_val("rst_pc", 32'(InstAddress), 32'd0);
    check_val("rst_running", 32'(Running), 32'd0);
    check_val("rst_done", 32'(Done), 32'd0);
    check_val("rst_count", 32'(InstCount), 32'd0);
    nop();
    check_val("idle_hold_pc", 32'(InstAddress), 32'd0);

    // Start, straight-line run, halt at 5
    cyc(0, 1, 0, 0, 0, 0, 6'd0, 0, 6'd0, 10'd0);
    check_val("start_running", 32'(Running), 32'd1);
    check_val("start_pc", 32'(InstAddress), 32'd0);
    for (int i = 0; i < 5; i++) nop();
    check_val("seq_pc5", 32'(InstAddress), 32'd5);
    cyc(0, 0, 0, 1, 0, 0, 6'd0, 0, 6'd0, 10'd0);
    check_val("halt_done", 32'(Done), 32'd1);
    check_val("halt_running", 32'(Running), 32'd0);
    check_val("halt_pc", 32'(InstAddress), 32'd5);
`ifdef INST_FETCH_CYCLE_CNT_EN
    check_val("halt_count", 32'(InstCount), 32'd6);
`endif
    nop();
    check_val("done_hold_pc", 32'(InstAddress), 32'd5);

    // Restart from DONE
    cyc(0, 1, 0, 0, 0, 0, 6'd0, 0, 6'd0, 10'd0);
    check_val("restart_pc", 32'(InstAddress), 32'd0);
    check_val("restart_done", 32'(Done), 32'd0);
    check_val("restart_running", 32'(Running), 32'd1);

    // Relative branches
    run_to(10'd12);
    br_rel(6'b111100);
    check_val("rel_back4", 32'(InstAddress), 32'd8);
    br_rel(6'd0);
    check_val("rel_selfloop", 32'(InstAddress), 32'd8);
    lut_wr(6'd1, 10'd1020);
    br_lut(6'd1);
    check_val("lut_to_1020", 32'(InstAddress), 32'd1020);
    br_rel(6'd5);
    check_val("rel_wrap", 32'(InstAddress), 32'd1);

    // LUT-indirect with same-cycle write (read before write)
    lut_wr(6'd0, 10'd200);
    run_to(10'd14);
    cyc(0, 0, 0, 0, 1, 1, 6'd0, 1, 6'd0, 10'd300);
    check_val("lut_old_entry", 32'(InstAddress), 32'd200);
    br_lut(6'd0);
    check_val("lut_new_entry", 32'(InstAddress), 32'd300);

    // Stall outranks halt and branch
    lut_wr(6'd2, 10'd7);
    lut_wr(6'd4, 10'd1023);
    br_lut(6'd2);
    check_val("lut_to_7", 32'(InstAddress), 32'd7);
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 1, 1, 1, 0, 6'd3, 0, 6'd0, 10'd0);
      check_val("stall_pc", 32'(InstAddress), 32'd7);
      check_val("stall_no_done", 32'(Done), 32'd0);
    end
    cyc(0, 0, 0, 1, 0, 0, 6'd0, 0, 6'd0, 10'd0);
    check_val("stall_release_done", 32'(Done), 32'd1);
    check_val("stall_release_pc", 32'(InstAddress), 32'd7);

    // PC wrap, Start ignored in RUN
    cyc(0, 1, 0, 0, 0, 0, 6'd0, 0, 6'd0, 10'd0);
    br_lut(6'd4);
    check_val("lut_to_1023", 32'(InstAddress), 32'd1023);
    nop();
    check_val("inc_wrap", 32'(InstAddress), 32'd0);
    for (int i = 1; i <= 3; i++) begin
      cyc(0, 1, 0, 0, 0, 0, 6'd0, 0, 6'd0, 10'd0);
      check_val("start_in_run_pc", 32'(InstAddress), 32'(i));
    end

    // Reset mid-run with a pending branch and LUT write
    lut_wr(6'd3, 10'd40);
    br_lut(6'd3);
    check_val("lut_to_40", 32'(InstAddress), 32'd40);
    cyc(1, 1, 0, 1, 1, 1, 6'd3, 1, 6'd5, 10'd99);
    check_val("midrst_pc", 32'(InstAddress), 32'd0);
    check_val("midrst_running", 32'(Running), 32'd0);
    check_val("midrst_done", 32'(Done), 32'd0);
    nop();
    check_val("midrst_idle_pc", 32'(InstAddress), 32'd0);
    cyc(0, 1, 0, 0, 0, 0, 6'd0, 0, 6'd0, 10'd0);
    nop();
    br_lut(6'd1);
    check_val("lut_cleared", 32'(InstAddress), 32'd0);

    // Random traffic against the model
    for (int i = 0; i < 400; i++) begin
      cyc(($urandom_range(63) == 0), ($urandom_range(7) == 0), ($urandom_range(4) == 0),
          ($urandom_range(15) == 0), ($urandom_range(3) == 0), 1'($urandom_range(1)),
          6'($urandom_range(63)), ($urandom_range(3) == 0), 6'($urandom_range(63)),
          10'($urandom_range(1023)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
